// File: rtl/canvas_dump.sv
// canvas_dump: streams the 4-bit colour canvas out as bytes.
//
// Walks the frame buffer linearly through a spare BRAM read port, packs two
// pixels per byte (even address in the low nibble) and emits the frame on a
// valid/ready byte stream, preceded by SYNC_BYTE.
//
// Ports:
//   pixel_clk_in  clock
//   rst_in        asynchronous reset, active low
//   start_in      one-cycle dump request (ignored while busy)
//   mem_addr_out  BRAM read address (x + H_ACTIVE*y)
//   mem_data_in   BRAM read data, READ_LATENCY cycles after the address
//   data_out      stream byte
//   valid_out     data_out valid
//   ready_in      downstream accept
//   busy_out      high from start acceptance until the last byte is accepted
//   done_out      one-cycle pulse after the last byte handshake
module canvas_dump #(
   parameter int         H_ACTIVE     = 640,
   parameter int         V_ACTIVE     = 360,
   parameter int         READ_LATENCY = 2,
   parameter int         FIFO_DEPTH   = 8,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   localparam int        DEPTH        = H_ACTIVE * V_ACTIVE,
   localparam int        AW           = $clog2(DEPTH)
) (
   input  logic          pixel_clk_in,
   input  logic          rst_in,
   input  logic          start_in,
   output logic [AW-1:0] mem_addr_out,
   input  logic [3:0]    mem_data_in,
   output logic [7:0]    data_out,
   output logic          valid_out,
   input  logic          ready_in,
   output logic          busy_out,
   output logic          done_out
);

   localparam int CW = $clog2(DEPTH) + 1;          // no wrap at DEPTH
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, SYNC, STREAM, FINISH} state_t;

   state_t                  state_q;
   logic [CW-1:0]           issued_q;
   logic [CW-1:0]           sent_q;
   logic [AW-1:0]           mem_addr_q;
   logic [READ_LATENCY-1:0] vld_pipe_q;
   logic [3:0]              fifo_mem_q [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [FW-1:0]           fifo_cnt_q, fifo_cnt_d;
   logic [7:0]              data_q;
   logic                    valid_q, busy_q, done_q;

   logic                    active, issue, push, pop, hs, last_hs;
   int                      inflight;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      inflight = 0;
      for (int i = 0; i < READ_LATENCY; i++)
         inflight += int'(vld_pipe_q[i]);
      active  = (state_q == SYNC) || (state_q == STREAM);
      hs      = valid_q && ready_in;
      // Credit rule: FIFO occupancy plus reads still in the BRAM pipe never
      // exceeds FIFO_DEPTH, so every returning nibble has a slot.
      issue   = active && (issued_q < CW'(DEPTH)) &&
                ((int'(fifo_cnt_q) + inflight) < FIFO_DEPTH);
      push    = vld_pipe_q[READ_LATENCY-1];
      // Load a new byte when the output slot is free or is being accepted
      // now; in SYNC the slot holds the sync byte, so this needs hs there.
      pop     = active && (fifo_cnt_q >= FW'(2)) && (!valid_q || ready_in);
      last_hs = (state_q == STREAM) && hs && (sent_q == CW'(DEPTH/2 - 1));
      fifo_cnt_d = fifo_cnt_q + FW'(push) - (pop ? FW'(2) : FW'(0));
   end

   // FIFO storage needs no reset; pointers and count define emptiness.
   always_ff @(posedge pixel_clk_in) begin
      if (push) fifo_mem_q[wr_ptr_q] <= mem_data_in;
   end

   always_ff @(posedge pixel_clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= IDLE;
         issued_q   <= '0;
         sent_q     <= '0;
         mem_addr_q <= '0;
         vld_pipe_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         // Read issue and return pipe
         vld_pipe_q[0] <= issue;
         for (int i = 1; i < READ_LATENCY; i++)
            vld_pipe_q[i] <= vld_pipe_q[i-1];
         if (issue) begin
            issued_q <= issued_q + 1'b1;
            // Hold at DEPTH-1 after the final read rather than wrapping
            if (issued_q != CW'(DEPTH - 1))
               mem_addr_q <= mem_addr_q + 1'b1;
         end

         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(ptr_inc(rd_ptr_q));
         fifo_cnt_q <= fifo_cnt_d;

         case (state_q)
            IDLE: begin
               if (start_in) begin
                  state_q    <= SYNC;
                  busy_q     <= 1'b1;
                  valid_q    <= 1'b1;
                  data_q     <= SYNC_BYTE;
                  issued_q   <= '0;
                  sent_q     <= '0;
                  mem_addr_q <= '0;
               end
            end
            SYNC: begin
               if (hs) begin
                  state_q <= STREAM;
                  if (pop) data_q <= {fifo_mem_q[ptr_inc(rd_ptr_q)], fifo_mem_q[rd_ptr_q]};
                  valid_q <= pop;
               end
            end
            STREAM: begin
               if (hs) sent_q <= sent_q + 1'b1;
               if (last_hs) begin
                  state_q    <= FINISH;
                  valid_q    <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  mem_addr_q <= '0;
               end else if (pop) begin
                  data_q  <= {fifo_mem_q[ptr_inc(rd_ptr_q)], fifo_mem_q[rd_ptr_q]};
                  valid_q <= 1'b1;
               end else if (hs) begin
                  valid_q <= 1'b0;
               end
            end
            FINISH: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_addr_out = mem_addr_q;
   assign data_out     = data_q;
   assign valid_out    = valid_q;
   assign busy_out     = busy_q;
   assign done_out     = done_q;

endmodule

// File: tb/tb_canvas_dump.sv
// Bench for canvas_dump: 8x4 canvas, two-stage registered BRAM model with
// pixel[i] = i[3:0], scoreboard queue of expected stream bytes.
module tb_canvas_dump;

   localparam int H = 8, V = 4, DEPTH = H * V, RL = 2;
   localparam int AW = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_data;
   logic [7:0]    data;
   logic          valid, ready, busy, done;

   canvas_dump #(.H_ACTIVE(H), .V_ACTIVE(V), .READ_LATENCY(RL),
                 .FIFO_DEPTH(8), .SYNC_BYTE(8'hA5)) dut (
      .pixel_clk_in(clk), .rst_in(rst_n), .start_in(start),
      .mem_addr_out(mem_addr), .mem_data_in(mem_data),
      .data_out(data), .valid_out(valid), .ready_in(ready),
      .busy_out(busy), .done_out(done));

   always #5 clk = ~clk;

   // BRAM model: two registered stages
   logic [3:0] r1, r2;
   always @(posedge clk) begin
      r1 <= mem_addr[3:0];
      r2 <= r1;
   end
   assign mem_data = r2;

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
      end
   endtask

   logic [7:0] exp_q[$];
   int rmode = 0;      // 0: ready high, 1: 30% random, 2: held low
   int cyc = 0, acc = 0, done_cnt = 0, fmax = 0;
   logic stab_pend = 1'b0;
   logic [7:0] hold_d = '0;

   always @(posedge clk) cyc++;

   always begin
      @(posedge clk); #1;
      ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 99) < 30) : 1'b0;
   end

   // Output monitor / scoreboard consumer
   always @(negedge clk) begin
      if (int'(dut.fifo_cnt_q) > fmax) fmax = int'(dut.fifo_cnt_q);
      if (rst_n) begin
         if (stab_pend) begin
            chk("hold_valid", valid, 1);
            chk("hold_data", data, hold_d);
         end
         stab_pend = valid && !ready;
         hold_d    = data;
         if (valid && ready) begin
            if (exp_q.size() == 0) chk("extra_byte", data, 32'h100);
            else chk("byte", data, exp_q.pop_front());
            acc++;
         end
         if (done) begin
            done_cnt++;
            chk("busy_at_done", busy, 0);
         end
      end else begin
         stab_pend = 1'b0;
      end
   end

   task automatic push_dump();
      exp_q.push_back(8'hA5);
      for (int k = 0; k < DEPTH/2; k++)
         exp_q.push_back({4'((2*k+1) % 16), 4'((2*k) % 16)});
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      do begin @(negedge clk); n++; end while (!done && n < budget);
      chk("done_seen", done, 1);
   endtask

   initial begin
      int d0, t0, t1, n;
      ready = 1'b1;
      #2;
      chk("rst_addr", mem_addr, 0);
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Basic dump
      d0 = done_cnt;
      push_dump();
      pulse_start();
      @(negedge clk);
      chk("sync_valid", valid, 1);
      chk("sync_data", data, 8'hA5);
      chk("busy_on", busy, 1);
      wait_done(200);
      chk("addr_at_done", mem_addr, 0);
      chk("busy_off", busy, 0);
      repeat (3) @(negedge clk);
      chk("basic_done_cnt", done_cnt - d0, 1);
      chk("basic_q_empty", exp_q.size(), 0);

      // Backpressure
      rmode = 1;
      push_dump();
      pulse_start();
      wait_done(2000);
      repeat (2) @(negedge clk);
      chk("bp_q_empty", exp_q.size(), 0);
      rmode = 0;

      // Stall in SYNC
      rmode = 2;
      @(posedge clk); #2;
      push_dump();
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("stall_valid", valid, 1);
         chk("stall_data", data, 8'hA5);
      end
      chk("stall_addr", mem_addr, 8);
      rmode = 0;
      wait_done(200);
      repeat (2) @(negedge clk);
      chk("stall_q_empty", exp_q.size(), 0);

      // Ignored start: mid-dump and in the done cycle
      d0 = done_cnt;
      push_dump();
      pulse_start();
      repeat (8) @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 200);
      chk("ign_done_seen", done, 1);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (60) @(negedge clk);
      chk("ign_done_cnt", done_cnt - d0, 1);
      chk("ign_q_empty", exp_q.size(), 0);
      chk("ign_busy", busy, 0);

      // Reset mid-operation
      d0 = done_cnt;
      acc = 0;
      push_dump();
      pulse_start();
      n = 0;
      do begin @(negedge clk); n++; end while (acc < 6 && n < 200);
      chk("rst_reach_b5", acc >= 6, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_data", data, 0);
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      exp_q.delete();
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_no_done", done_cnt - d0, 0);
      chk("rst_idle_valid", valid, 0);
      push_dump();
      pulse_start();
      wait_done(200);
      repeat (2) @(negedge clk);
      chk("post_rst_q_empty", exp_q.size(), 0);

      // Throughput
      push_dump();
      pulse_start();
      n = 0;
      while (!(valid && ready) && n < 50) begin @(negedge clk); n++; end
      t0 = cyc;
      wait_done(200);
      t1 = cyc;
      chk("throughput", (t1 - 1 - t0) <= 32 + RL + 3, 1);
      repeat (2) @(negedge clk);
      chk("thru_q_empty", exp_q.size(), 0);

      chk("fifo_max", fmax <= 8, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/canvas_dump.md
Name: canvas_dump

Overview:
- Read-side companion to the paint canvas frame buffer.
- Walks the 4-bit colour canvas linearly through a spare BRAM read port and packs two pixels per byte.
- Emits the frame as a byte stream on a valid/ready interface, preceded by a sync byte.
- Feeds the UART/host "save canvas" path. Tolerates the registered BRAM read latency and arbitrary downstream backpressure.

Parameters:
- H_ACTIVE, 640, canvas width in pixels.
- V_ACTIVE, 360, canvas height in pixels; DEPTH = H_ACTIVE*V_ACTIVE, must be even.
- READ_LATENCY, 2, cycles from mem_addr_out to valid mem_data_in (HIGH_PERFORMANCE BRAM).
- FIFO_DEPTH, 8, internal pixel (nibble) FIFO entries; must be >= READ_LATENCY+2.
- SYNC_BYTE, 8'hA5, first byte of every dump.

Ports:
- pixel_clk_in  input  1  the single clock.
- rst_in  input  1  asynchronous, active-low reset (0 = reset).
- start_in  input  1  one-cycle request to dump the canvas.
- mem_addr_out  output  $clog2(DEPTH)  BRAM read address (address = x + H_ACTIVE*y, traversed linearly).
- mem_data_in  input  4  BRAM read data, valid READ_LATENCY cycles after the address.
- data_out  output  8  stream byte.
- valid_out  output  1  data_out valid.
- ready_in  input  1  downstream accepts the byte when valid_out && ready_in.
- busy_out  output  1  high from start acceptance until the last byte is accepted.
- done_out  output  1  one-cycle pulse after the last byte handshake.

Behaviour:
- Reset values: mem_addr_out=0, data_out=0, valid_out=0, busy_out=0, done_out=0. FIFO is empty, in-flight pipe is cleared, state is IDLE.
- Reset mid-dump aborts immediately. No done_out is pulsed. The next dump requires a new start_in.
- States: IDLE, SYNC, STREAM, FINISH.
- IDLE: start_in=1 -> SYNC, with busy_out=1 on the next edge.
- SYNC:
  - valid_out=1, data_out=SYNC_BYTE, presented the cycle after start.
  - On handshake -> STREAM.
  - Pixel reads may already be issued during SYNC.
- Read issue:
  - One read per cycle while issued_count < DEPTH and fifo_count + inflight_count < FIFO_DEPTH.
  - mem_addr_out increments by 1 per issued read, from 0 to DEPTH-1.
  - A READ_LATENCY-long valid shift register tags returning data. Tagged mem_data_in is pushed into the FIFO.
  - The credit rule guarantees the FIFO never overflows. An overflow is a design error; the bench asserts against it.
- Packing, in STREAM:
  - When no byte is pending and the FIFO holds >= 2 entries, pop two pixels.
  - The first-read pixel (even address) goes to data_out[3:0], the second to data_out[7:4]. valid_out=1.
- Handshake rules:
  - While valid_out && !ready_in, data_out and valid_out hold stable.
  - A new byte may be loaded in the same cycle the previous one is accepted, so there are no bubbles when data is available.
- Throughput: sustained 1 byte / 2 cycles with ready_in held at 1 (read-port bound).
- Last byte:
  - After DEPTH/2 pixel bytes are accepted -> FINISH for one cycle: done_out=1, busy_out drops the same cycle, mem_addr_out resets to 0.
  - Then IDLE.
- start_in while busy_out=1 is ignored. start_in in the same cycle as done_out is ignored.
- Total bytes per dump = 1 + DEPTH/2. Counters are sized $clog2(DEPTH)+1 to avoid wrap at DEPTH.
- ready_in may be low for any number of cycles, including during SYNC. No data is lost or duplicated.

Test Plan:
- Setup for all scenarios:
  - H_ACTIVE=8, V_ACTIVE=4 (DEPTH=32), READ_LATENCY=2.
  - Bench BRAM model with pixel[i]=i[3:0].
  - ready_in=1 unless stated.
- Basic dump: pulse start_in -> sync 8'hA5 the next cycle, then 16 bytes 8'h10, 8'h32, ..., 8'hFE, 8'h10, ..., 8'hFE. done_out pulses once. busy_out drops with done_out. mem_addr_out returns to 0.
- Backpressure: ready_in driven by pseudo-random 30% duty -> identical 17-byte sequence. data_out is stable whenever valid_out && !ready_in. The FIFO never exceeds 8 entries.
- Stall in SYNC: ready_in=0 for 20 cycles after start -> valid_out=1 with data_out=8'hA5 held for all 20 cycles. mem_addr_out stops advancing after 8 reads are issued. The stream is correct once released.
- Ignored start: pulse start_in mid-dump and again in the done_out cycle -> exactly one 17-byte dump and exactly one done_out.
- Reset mid-operation: assert rst_in=0 asynchronously after byte 5 -> all outputs 0 immediately, no done_out. A fresh start produces a full correct dump beginning with 8'hA5.
- Throughput: ready_in=1 throughout -> the 16 pixel bytes are accepted within 32+READ_LATENCY+3 cycles of the sync handshake.
